// File: rtl/fd_pkg.sv
// Shared types and defaults for the divided-clock period meter.
package fd_pkg;

    localparam int unsigned FD_WIDTH       = 32;
    localparam int unsigned FD_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } fd_meter_state_t;

endpackage

// File: rtl/freq_div_meter_if.sv
// Control/result bundle between a meter and whoever drives and observes it.
interface freq_div_meter_if
    import fd_pkg::*;
#(
    parameter int unsigned WIDTH = FD_WIDTH
) ();

    logic             enable;
    logic             sig_in;
    logic             clear_stat;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             overflow;

    modport master (
        output enable, sig_in, clear_stat,
        input  period, high_time, valid, locked, overflow
    );

    modport slave (
        input  enable, sig_in, clear_stat,
        output period, high_time, valid, locked, overflow
    );

endinterface

// File: rtl/fd_edge_sync.sv
// Multi-flop synchronizer for an asynchronous input followed by registered rise/fall detection.
module fd_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic rise,
    output logic fall
);

    // Fewer than two stages is not a synchronizer; clamp silently.
    localparam int unsigned STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig};
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
            fall   <= ~sync_q[STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/freq_div_meter.sv
// Measures the period (and optionally the high phase) of a divided clock in Clk cycles.
// Optional duty-cycle capture is built when FREQ_DIV_METER_DUTY_MEASURE_EN is defined.
module freq_div_meter
    import fd_pkg::*;
#(
    parameter int unsigned      WIDTH       = FD_WIDTH,
    parameter int unsigned      SYNC_STAGES = FD_SYNC_STAGES,
    parameter logic [WIDTH-1:0] MAX_COUNT   = {WIDTH{1'b1}}
) (
    input logic             Clk,
    input logic             Reset,
    freq_div_meter_if.slave bus
);

    fd_meter_state_t  state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             prev_ok_q, prev_ok_d;
    logic             ovf_q, ovf_d;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] duty_high;

    fd_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk  (Clk),
        .rst  (Reset),
        .sig  (bus.sig_in),
        .rise (rise),
        .fall (fall)
    );

`ifdef FREQ_DIV_METER_DUTY_MEASURE_EN
    logic [WIDTH-1:0] hi_q;
    logic             fall_seen_q;

    // High phase is the count at the fall; reported only if a fall happened this period.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hi_q        <= '0;
            fall_seen_q <= 1'b0;
        end else if (!bus.enable || rise) begin
            fall_seen_q <= 1'b0;
        end else if (state_q == MEASURE && fall) begin
            hi_q        <= cnt_q;
            fall_seen_q <= 1'b1;
        end
    end

    assign duty_high = fall_seen_q ? hi_q : '0;
`else
    logic unused_fall;

    assign unused_fall = fall;
    assign duty_high   = '0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            prev_ok_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            prev_ok_q <= prev_ok_d;
            ovf_q     <= ovf_d;
        end
    end

    // prev_ok marks that period_q holds a period measured in the current run.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        prev_ok_d = prev_ok_q;
        ovf_d     = ovf_q;

        if (bus.clear_stat) begin
            ovf_d = 1'b0;
        end

        if (!bus.enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            locked_d  = 1'b0;
            prev_ok_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = ARM;
                    locked_d  = 1'b0;
                    prev_ok_d = 1'b0;
                end
                ARM: begin
                    locked_d  = 1'b0;
                    prev_ok_d = 1'b0;
                    if (rise) begin
                        cnt_d   = WIDTH'(1);
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d  = cnt_q;
                        high_d    = duty_high;
                        valid_d   = 1'b1;
                        locked_d  = prev_ok_q && (cnt_q == period_q);
                        prev_ok_d = 1'b1;
                        cnt_d     = WIDTH'(1);
                    end else if (cnt_q >= MAX_COUNT) begin
                        // Timeout: the set overrides a same-cycle clear.
                        ovf_d     = 1'b1;
                        locked_d  = 1'b0;
                        prev_ok_d = 1'b0;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign bus.period    = period_q;
    assign bus.high_time = high_q;
    assign bus.valid     = valid_q;
    assign bus.locked    = locked_q;
    assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_freq_div_meter.sv
// Randomized and directed bench for freq_div_meter against a waveform-timing reference model.
module tb_freq_div_meter;

    localparam int unsigned W    = 16;
    localparam int          MAXC = 16;
    localparam int          LAT  = 4;   // bench drive to FSM sampling of the edge
`ifdef FREQ_DIV_METER_DUTY_MEASURE_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    typedef struct {
        int per;
        int hi;
        bit lk;
    } rec_t;

    logic clk = 1'b0;
    logic rst;

    freq_div_meter_if #(.WIDTH(W)) bus ();

    freq_div_meter #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .MAX_COUNT   (W'(MAXC))
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];

    // Reference model: derived purely from the times of driven edges.
    bit have_last, fall_seen, prev_ok, exp_ovf, exp_lock;
    int last_rise, fall_c, prev_per, exp_per, exp_hi;

    always @(negedge clk) begin
        if (bus.valid === 1'b1)
            obs_q.push_back('{int'(bus.period), int'(bus.high_time), bus.locked});
    end

    task automatic chk(input string tag, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        have_last = 0; fall_seen = 0; prev_ok = 0; exp_ovf = 0; exp_lock = 0;
        last_rise = 0; fall_c = 0; prev_per = 0; exp_per = 0; exp_hi = 0;
    endtask

    task automatic model_disable();
        have_last = 0; prev_ok = 0; exp_lock = 0;
    endtask

    // A measurement with no rise for MAXC cycles times out LAT cycles after drive time.
    task automatic settle();
        if (have_last && (cyc - last_rise) >= MAXC + LAT) begin
            exp_ovf = 1; exp_lock = 0; prev_ok = 0; have_last = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        settle();
    endtask

    task automatic pause(input int n);
        repeat (n) step();
    endtask

    task automatic set_sig(input logic v);
        int gap;
        int hi;
        bit lk;
        if (v && !bus.sig_in) begin
            if (have_last) begin
                gap = cyc - last_rise;
                if (gap <= MAXC) begin
                    hi = (DUTY && fall_seen) ? (fall_c - last_rise) : 0;
                    lk = prev_ok && (gap == prev_per);
                    exp_q.push_back('{gap, hi, lk});
                    prev_per = gap; prev_ok = 1; exp_lock = lk; exp_per = gap; exp_hi = hi;
                end else begin
                    exp_ovf = 1; exp_lock = 0; prev_ok = 0;
                end
            end
            have_last = 1; last_rise = cyc; fall_seen = 0;
        end else if (!v && bus.sig_in && have_last) begin
            fall_seen = 1; fall_c = cyc;
        end
        bus.sig_in = v;
    endtask

    task automatic drive(input int h, input int l, input int n);
        repeat (n) begin
            set_sig(1'b1);
            pause(h);
            set_sig(1'b0);
            pause(l);
        end
    endtask

    task automatic compare(input string tag);
        chk($sformatf("%s_count", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_per%0d", tag, i), obs_q[i].per, exp_q[i].per);
            chk($sformatf("%s_hi%0d", tag, i), obs_q[i].hi, exp_q[i].hi);
            chk($sformatf("%s_lk%0d", tag, i), obs_q[i].lk, exp_q[i].lk);
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    initial begin
        int k;
        rst = 1'b1;
        bus.enable = 1'b0; bus.sig_in = 1'b0; bus.clear_stat = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_period", bus.period, 0);
        chk("rst_high", bus.high_time, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_overflow", bus.overflow, 0);
        rst = 1'b0;
        step();
        bus.enable = 1'b1;
        pause(6);

        // Divisor 4, then reprogram to 6 while locked.
        drive(2, 2, 6);
        chk("din4_period", bus.period, 4);
        chk("din4_high", bus.high_time, DUTY ? 2 : 0);
        chk("din4_locked", bus.locked, 1);
        drive(3, 3, 4);
        pause(8);
        compare("din4_6");
        chk("din6_locked", bus.locked, exp_lock);

        // Divisor 5, minimum period 2, period equal to MAX_COUNT, then a timeout gap.
        drive(2, 3, 4);
        pause(8);
        compare("din5");
        chk("din5_period", bus.period, 5);
        chk("din5_high", bus.high_time, DUTY ? 2 : 0);
        drive(1, 1, 5);
        drive(8, 8, 3);
        drive(2, 15, 2);
        drive(2, 2, 3);
        pause(8);
        compare("edges");
        chk("edges_overflow", bus.overflow, 1);
        pause(25);
        bus.clear_stat = 1'b1;
        step();
        bus.clear_stat = 1'b0;
        exp_ovf = 0;
        step();
        chk("clear_overflow", bus.overflow, 0);

        // Randomized waveforms, some with gaps beyond MAX_COUNT.
        for (int s = 0; s < 14; s++) begin
            int h, l, n;
            h = $urandom_range(1, 9);
            l = ($urandom_range(0, 5) == 0) ? $urandom_range(14, 20) : $urandom_range(1, 9);
            n = $urandom_range(1, 4);
            drive(h, l, n);
        end
        pause(8);
        compare("rand");
        chk("rand_overflow", bus.overflow, exp_ovf);
        chk("rand_locked", bus.locked, exp_lock);
        chk("rand_period", bus.period, exp_per);
        chk("rand_high", bus.high_time, exp_hi);

        // Enable dropped mid-period: results hold, lock drops, first edge after re-enable is silent.
        drive(2, 3, 3);
        set_sig(1'b1);
        pause(2);
        set_sig(1'b0);
        pause(4);
        bus.enable = 1'b0;
        model_disable();
        pause(2);
        chk("dis_locked", bus.locked, 0);
        chk("dis_period_hold", bus.period, 5);
        chk("dis_high_hold", bus.high_time, DUTY ? 2 : 0);
        pause(3);
        bus.enable = 1'b1;
        pause(6);
        drive(2, 3, 3);
        pause(8);
        compare("reenable");

        // Timeout coinciding with ClearStat: the set must win.
        pause(25);
        bus.clear_stat = 1'b1;
        step();
        bus.clear_stat = 1'b0;
        exp_ovf = 0;
        set_sig(1'b1);
        pause(2);
        set_sig(1'b0);
        pause(2);
        set_sig(1'b1);
        k = cyc;
        pause(2);
        set_sig(1'b0);
        while (cyc < k + MAXC + LAT - 1) step();
        chk("ovf_not_early", bus.overflow, 0);
        bus.clear_stat = 1'b1;
        step();
        bus.clear_stat = 1'b0;
        chk("ovf_set_wins", bus.overflow, 1);
        chk("ovf_model", bus.overflow, exp_ovf);
        step();
        chk("ovf_sticky", bus.overflow, 1);
        compare("timeout");

        // Reset mid-period clears every output at once.
        drive(2, 2, 4);
        pause(4);
        compare("pre_reset");
        chk("pre_reset_locked", bus.locked, 1);
        chk("pre_reset_ovf", bus.overflow, 1);
        rst = 1'b1;
        model_reset();
        #2;
        chk("midrst_period", bus.period, 0);
        chk("midrst_high", bus.high_time, 0);
        chk("midrst_valid", bus.valid, 0);
        chk("midrst_locked", bus.locked, 0);
        chk("midrst_overflow", bus.overflow, 0);
        step();
        rst = 1'b0;
        pause(5);
        drive(2, 2, 2);
        pause(25);
        compare("post_reset");
        chk("post_reset_ovf", bus.overflow, 1);
        bus.clear_stat = 1'b1;
        step();
        bus.clear_stat = 1'b0;
        exp_ovf = 0;
        step();
        chk("post_reset_clear", bus.overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
